// File: rtl/lms_anc_pkg.sv
// lms_anc_pkg: shared FSM/mode enums, width helpers and saturating/rounding arithmetic for the LMS canceller
package lms_anc_pkg;
  typedef enum logic [1:0] {IDLE, MAC, ERR, UPD} lms_state_t;
  typedef enum logic {LMS_FULL, LMS_SIGN} lms_mode_t;
  function automatic int acc_width(input int dw, ww, n);
    return dw + ww + $clog2(n);
  endfunction
  function automatic int upd_shift(input int dw, ww, mu);
    return 2 * dw - 1 - ww + mu;
  endfunction
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    return v > hi ? hi : v < -hi - 64'sd1 ? -hi - 64'sd1 : v;
  endfunction
  function automatic logic signed [63:0] round_shr(input logic signed [63:0] v, input int s);
    return s <= 0 ? v : (v + (64'sd1 <<< (s - 1))) >>> s;
  endfunction
endpackage

// File: rtl/lms_anc_if.sv
// lms_anc_if: sample handshake (in_vld/in_rdy, xin, yin, mode, freeze, wclr) and result bus (eo, out_vld, out_sat)
interface lms_anc_if #(parameter int DW = 16);
  logic in_vld, in_rdy, mode, freeze, wclr, out_vld, out_sat;
  logic signed [DW-1:0] xin, yin, eo;
  modport master(output in_vld, xin, yin, mode, freeze, wclr, input in_rdy, eo, out_vld, out_sat);
  modport slave(input in_vld, xin, yin, mode, freeze, wclr, output in_rdy, eo, out_vld, out_sat);
endinterface

// File: rtl/lms_anc_engine_tap_store.sv
// lms_tap_store: x history shift register (shift_i/x_i) and weight file (we_i/w_i), shared read port at idx_i (x_o/w_o), sync clear clr_i
module lms_tap_store #(
  parameter int DW = 16,
  parameter int WW = 16,
  parameter int NTAPS = 8,
  parameter int IW = $clog2(NTAPS)
) (
  input  logic                 clk,
  input  logic                 clr_i,
  input  logic                 shift_i,
  input  logic signed [DW-1:0] x_i,
  input  logic        [IW-1:0] idx_i,
  input  logic                 we_i,
  input  logic signed [WW-1:0] w_i,
  output logic signed [DW-1:0] x_o,
  output logic signed [WW-1:0] w_o
);
  logic signed [DW-1:0] x_q [NTAPS];
  logic signed [WW-1:0] w_q [NTAPS];
  always_ff @(posedge clk) begin
    if (clr_i) begin
      for (int k = 0; k < NTAPS; k++) begin
        x_q[k] <= '0;
        w_q[k] <= '0;
      end
    end else begin
      if (shift_i) begin
        x_q[0] <= x_i;
        for (int k = 1; k < NTAPS; k++) x_q[k] <= x_q[k-1];
      end
      if (we_i) w_q[idx_i] <= w_i;
    end
  end
  assign x_o = x_q[idx_i];
  assign w_o = w_q[idx_i];
endmodule

// File: rtl/lms_anc_engine.sv
// lms_anc_engine: single-MAC LMS noise canceller; clk, rst_n (sync, active-low), bus = lms_anc_if.slave (sample in, error out)
module lms_anc_engine
  import lms_anc_pkg::*;
#(
  parameter int DW = 16,
  parameter int WW = 16,
  parameter int NTAPS = 8,
  parameter int MU_SHIFT = 6
) (
  input logic clk,
  input logic rst_n,
  lms_anc_if.slave bus
);
  localparam int ACCW = acc_width(DW, WW, NTAPS);
  localparam int US = upd_shift(DW, WW, MU_SHIFT);
  localparam int IW = $clog2(NTAPS);
  lms_state_t state_q, state_d;
  lms_mode_t mode_q, mode_d;
  logic [IW-1:0] idx_q, idx_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic signed [DW-1:0] y_q, y_d, eo_q, eo_d, x_rd;
  logic signed [WW-1:0] w_rd, w_new;
  logic signed [DW+WW-1:0] prod;
  logic signed [63:0] z_raw, z_sat, e_raw, e_sat, ew, mag, delta;
  logic frz_q, frz_d, vld_q, vld_d, sat_q, sat_d, accept, last, we;
  assign accept = bus.in_vld && state_q == IDLE && !bus.wclr;
  assign last = idx_q == IW'(NTAPS - 1);
  assign prod = x_rd * w_rd;
  always_comb begin
    z_raw = round_shr(64'(acc_q), WW - 1);
    z_sat = sat_signed(z_raw, DW);
    e_raw = 64'(y_q) - z_sat;
    e_sat = sat_signed(e_raw, DW);
    ew = 64'(eo_q) <<< (WW - DW);
    mag = ew >>> MU_SHIFT;
    delta = mode_q == LMS_SIGN ? (x_rd > 0 ? mag : x_rd < 0 ? -mag : 64'sd0)
                               : round_shr(64'(eo_q) * 64'(x_rd), US);
    w_new = WW'(sat_signed(64'(w_rd) + delta, WW));
  end
  lms_tap_store #(.DW(DW), .WW(WW), .NTAPS(NTAPS)) u_store (
    .clk(clk), .clr_i(!rst_n || bus.wclr), .shift_i(accept), .x_i(bus.xin),
    .idx_i(idx_q), .we_i(we), .w_i(w_new), .x_o(x_rd), .w_o(w_rd)
  );
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    acc_d = acc_q;
    y_d = y_q;
    mode_d = mode_q;
    frz_d = frz_q;
    eo_d = eo_q;
    sat_d = sat_q;
    vld_d = 1'b0;
    we = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        state_d = MAC;
        idx_d = '0;
        acc_d = '0;
        y_d = bus.yin;
        mode_d = lms_mode_t'(bus.mode);
        frz_d = bus.freeze;
      end
      MAC: begin
        acc_d = acc_q + ACCW'(prod);
        idx_d = last ? '0 : idx_q + 1'b1;
        state_d = last ? ERR : MAC;
      end
      ERR: begin
        eo_d = DW'(e_sat);
        sat_d = (z_sat != z_raw) || (e_sat != e_raw);
        vld_d = 1'b1;
        state_d = frz_q ? IDLE : UPD;
      end
      UPD: begin
        we = 1'b1;
        idx_d = last ? '0 : idx_q + 1'b1;
        state_d = last ? IDLE : UPD;
      end
      default: state_d = IDLE;
    endcase
    if (bus.wclr) begin
      state_d = IDLE;
      idx_d = '0;
      eo_d = eo_q;
      sat_d = sat_q;
      vld_d = 1'b0;
      we = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q <= LMS_FULL;
      idx_q <= '0;
      acc_q <= '0;
      y_q <= '0;
      eo_q <= '0;
      frz_q <= 1'b0;
      vld_q <= 1'b0;
      sat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      idx_q <= idx_d;
      acc_q <= acc_d;
      y_q <= y_d;
      eo_q <= eo_d;
      frz_q <= frz_d;
      vld_q <= vld_d;
      sat_q <= sat_d;
    end
  end
  assign bus.in_rdy = state_q == IDLE;
  assign bus.eo = eo_q;
  assign bus.out_vld = vld_q;
  assign bus.out_sat = sat_q;
endmodule

// File: tb/tb_lms_anc_engine.sv
// tb_lms_anc_engine: scoreboard bench for lms_anc_engine at DW=8, WW=8, NTAPS=4, MU_SHIFT=2
module tb_lms_anc_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0, c0 = 0, pass_cnt = 0, total = 0;
  int mw[4], mx[4];
  int exp_e[$];
  bit exp_s[$];
  lms_anc_if #(.DW(8)) bus();
  lms_anc_engine #(.DW(8), .WW(8), .NTAPS(4), .MU_SHIFT(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rst_n && bus.out_vld) begin
      total++;
      if (exp_e.size() == 0) $display("FAIL unexpected_out_vld eo=%0d", $signed(bus.eo));
      else begin
        int ee;
        bit es;
        ee = exp_e.pop_front();
        es = exp_s.pop_front();
        if (int'($signed(bus.eo)) !== ee || bus.out_sat !== es)
          $display("FAIL scoreboard_eo got eo=%0d sat=%0b exp eo=%0d sat=%0b", $signed(bus.eo), bus.out_sat, ee, es);
        else pass_cnt++;
      end
    end
  end
  function automatic int clip(input int v);
    return v > 127 ? 127 : v < -128 ? -128 : v;
  endfunction
  function automatic void model_clear();
    for (int k = 0; k < 4; k++) begin
      mw[k] = 0;
      mx[k] = 0;
    end
  endfunction
  function automatic void model_step(input int x, y, input bit md, frz, output int e, output bit s);
    int acc, zr, z, er, d;
    for (int k = 3; k > 0; k--) mx[k] = mx[k-1];
    mx[0] = x;
    acc = 0;
    for (int k = 0; k < 4; k++) acc += mx[k] * mw[k];
    zr = (acc + 64) >>> 7;
    z = clip(zr);
    er = y - z;
    e = clip(er);
    s = (z != zr) || (e != er);
    if (!frz)
      for (int k = 0; k < 4; k++) begin
        d = md ? (mx[k] > 0 ? (e >>> 2) : mx[k] < 0 ? -(e >>> 2) : 0) : ((e * mx[k] + 256) >>> 9);
        mw[k] = clip(mw[k] + d);
      end
  endfunction
  task automatic send(input int x, y, input bit md, frz);
    int e;
    bit s;
    for (int n = 0; n < 40 && !bus.in_rdy; n++) @(negedge clk);
    if (!bus.in_rdy) begin
      total++;
      $display("FAIL send_in_rdy_timeout got=0 exp=1");
    end
    bus.in_vld = 1'b1;
    bus.xin = 8'(x);
    bus.yin = 8'(y);
    bus.mode = md;
    bus.freeze = frz;
    @(posedge clk);
    #1;
    c0 = cyc;
    bus.in_vld = 1'b0;
    model_step(x, y, md, frz, e, s);
    exp_e.push_back(e);
    exp_s.push_back(s);
  endtask
  task automatic wait_vld(output int dt);
    dt = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.out_vld) begin
        dt = cyc - c0;
        break;
      end
    end
  endtask
  task automatic wait_rdy(output int dt);
    dt = -1;
    for (int n = 0; n < 40; n++) begin
      if (bus.in_rdy) begin
        dt = cyc - c0;
        break;
      end
      @(negedge clk);
    end
  endtask
  task automatic test_reset();
    bus.in_vld = 1'b0;
    bus.xin = '0;
    bus.yin = '0;
    bus.mode = 1'b0;
    bus.freeze = 1'b0;
    bus.wclr = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total += 4;
    if (bus.eo !== 8'sd0) $display("FAIL reset_eo got=%0d exp=0", bus.eo); else pass_cnt++;
    if (bus.out_vld !== 1'b0) $display("FAIL reset_out_vld got=%0b exp=0", bus.out_vld); else pass_cnt++;
    if (bus.out_sat !== 1'b0) $display("FAIL reset_out_sat got=%0b exp=0", bus.out_sat); else pass_cnt++;
    if (bus.in_rdy !== 1'b1) $display("FAIL reset_in_rdy got=%0b exp=1", bus.in_rdy); else pass_cnt++;
    rst_n = 1'b1;
    model_clear();
  endtask
  task automatic test_sign_data();
    int dt, exp_w[4];
    exp_w = '{8, 0, 0, 0};
    send(64, 32, 1'b1, 1'b0);
    wait_vld(dt);
    total += 2;
    if (dt !== 5) $display("FAIL sign_vld_latency got=%0d exp=5", dt); else pass_cnt++;
    if (int'($signed(bus.eo)) !== 32) $display("FAIL sign_eo got=%0d exp=32", $signed(bus.eo)); else pass_cnt++;
    wait_rdy(dt);
    total++;
    if (dt !== 9) $display("FAIL sign_rdy_latency got=%0d exp=9", dt); else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (int'(dut.u_store.w_q[k]) !== exp_w[k]) $display("FAIL sign_w%0d got=%0d exp=%0d", k, dut.u_store.w_q[k], exp_w[k]);
      else pass_cnt++;
    end
  endtask
  task automatic test_saturation();
    int dt;
    send(-128, 127, 1'b1, 1'b0);
    wait_vld(dt);
    total += 2;
    if (int'($signed(bus.eo)) !== 127) $display("FAIL sat_eo got=%0d exp=127", $signed(bus.eo)); else pass_cnt++;
    if (bus.out_sat !== 1'b1) $display("FAIL sat_flag got=%0b exp=1", bus.out_sat); else pass_cnt++;
    wait_rdy(dt);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (int'(dut.u_store.w_q[k]) !== mw[k]) $display("FAIL sat_w%0d got=%0d exp=%0d", k, dut.u_store.w_q[k], mw[k]);
      else pass_cnt++;
    end
  endtask
  task automatic test_full_lms();
    int dt, e_last;
    bus.wclr = 1'b1;
    @(posedge clk);
    #1;
    bus.wclr = 1'b0;
    model_clear();
    send(64, 32, 1'b0, 1'b0);
    wait_vld(dt);
    wait_rdy(dt);
    total++;
    if (int'(dut.u_store.w_q[0]) !== 4) $display("FAIL full_w0 got=%0d exp=4", dut.u_store.w_q[0]); else pass_cnt++;
    e_last = 32;
    for (int i = 0; i < 39; i++) begin
      send(64, 32, 1'b0, 1'b0);
      wait_vld(dt);
      e_last = int'($signed(bus.eo));
    end
    wait_rdy(dt);
    total++;
    if (e_last > 3 || e_last < -3) $display("FAIL full_converge got=%0d exp=|eo|<=3", e_last); else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (int'(dut.u_store.w_q[k]) !== mw[k]) $display("FAIL full_w%0d got=%0d exp=%0d", k, dut.u_store.w_q[k], mw[k]);
      else pass_cnt++;
    end
  endtask
  task automatic test_freeze();
    int dt, e1, e2, snap[4];
    for (int k = 0; k < 4; k++) snap[k] = mw[k];
    send(64, 32, 1'b0, 1'b1);
    wait_vld(dt);
    e1 = int'($signed(bus.eo));
    wait_rdy(dt);
    total++;
    if (dt !== 5) $display("FAIL freeze_rdy1 got=%0d exp=5", dt); else pass_cnt++;
    send(64, 32, 1'b0, 1'b1);
    wait_vld(dt);
    e2 = int'($signed(bus.eo));
    wait_rdy(dt);
    total += 2;
    if (dt !== 5) $display("FAIL freeze_rdy2 got=%0d exp=5", dt); else pass_cnt++;
    if (e2 !== e1) $display("FAIL freeze_same_eo got=%0d exp=%0d", e2, e1); else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (int'(dut.u_store.w_q[k]) !== snap[k]) $display("FAIL freeze_w%0d got=%0d exp=%0d", k, dut.u_store.w_q[k], snap[k]);
      else pass_cnt++;
    end
  endtask
  task automatic test_wclr_mid();
    int dt, nv;
    bus.in_vld = 1'b1;
    bus.xin = 8'sd50;
    bus.yin = 8'sd20;
    bus.mode = 1'b0;
    bus.freeze = 1'b0;
    @(posedge clk);
    #1;
    bus.in_vld = 1'b0;
    @(posedge clk);
    #1;
    bus.wclr = 1'b1;
    @(posedge clk);
    #1;
    bus.wclr = 1'b0;
    model_clear();
    total++;
    if (bus.in_rdy !== 1'b1) $display("FAIL wclr_in_rdy got=%0b exp=1", bus.in_rdy); else pass_cnt++;
    nv = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus.out_vld) nv++;
    end
    total++;
    if (nv !== 0) $display("FAIL wclr_no_vld got=%0d exp=0", nv); else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (int'(dut.u_store.w_q[k]) !== 0) $display("FAIL wclr_w%0d got=%0d exp=0", k, dut.u_store.w_q[k]);
      else pass_cnt++;
    end
    send(40, -20, 1'b1, 1'b0);
    wait_vld(dt);
    total++;
    if (int'($signed(bus.eo)) !== -20) $display("FAIL wclr_eo got=%0d exp=-20", $signed(bus.eo)); else pass_cnt++;
    wait_rdy(dt);
  endtask
  task automatic test_rst_mid();
    int dt;
    send(64, 32, 1'b0, 1'b0);
    wait_vld(dt);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    total += 4;
    if (bus.eo !== 8'sd0) $display("FAIL rst_mid_eo got=%0d exp=0", bus.eo); else pass_cnt++;
    if (bus.out_vld !== 1'b0) $display("FAIL rst_mid_out_vld got=%0b exp=0", bus.out_vld); else pass_cnt++;
    if (bus.out_sat !== 1'b0) $display("FAIL rst_mid_out_sat got=%0b exp=0", bus.out_sat); else pass_cnt++;
    if (bus.in_rdy !== 1'b1) $display("FAIL rst_mid_in_rdy got=%0b exp=1", bus.in_rdy); else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (int'(dut.u_store.w_q[k]) !== 0) $display("FAIL rst_mid_w%0d got=%0d exp=0", k, dut.u_store.w_q[k]);
      else pass_cnt++;
    end
    rst_n = 1'b1;
    model_clear();
  endtask
  initial begin
    test_reset();
    test_sign_data();
    test_saturation();
    test_full_lms();
    test_freeze();
    test_wclr_mid();
    test_rst_mid();
    repeat (3) @(negedge clk);
    total++;
    if (exp_e.size() !== 0) $display("FAIL scoreboard_drain got=%0d exp=0", exp_e.size()); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
